// File: rtl/tow_bot_player.sv
// tow_bot_player: automated tug-of-war opponent pressing after a pseudo-random reaction delay
module tow_bot_player #(
  parameter int         DLY_W       = 8,
  parameter int         HOLD_CYCLES = 25,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             cue_i,
  input  logic [DLY_W-1:0] min_dly_i,
  input  logic [DLY_W-1:0] rnd_mask_i,
  input  logic             false_start_i,
  output logic             press_o,
  output logic             aborted_o,
  output logic             busy_o,
  output logic [7:0]       press_cnt_o
);
  typedef enum logic [2:0] {IDLE, ARMED, REACT, PRESS, RELEASE} state_t;
  state_t           state_q, state_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic [7:0]       lfsr_q, press_cnt_q, press_cnt_d;
  logic             cue_q, aborted_q, aborted_d;
  logic             rise;
  logic [DLY_W:0]   sum;
  logic [DLY_W-1:0] dly;
  assign rise        = cue_i & ~cue_q;
  assign sum         = {1'b0, min_dly_i} + {1'b0, DLY_W'(lfsr_q) & rnd_mask_i};
  assign dly         = sum[DLY_W] ? '1 : sum[DLY_W-1:0];
  assign press_o     = state_q == PRESS;
  assign busy_o      = state_q == REACT || state_q == PRESS || state_q == RELEASE;
  assign aborted_o   = aborted_q;
  assign press_cnt_o = press_cnt_q;
  // State, shared counter (false-start count / reaction countdown / hold), LFSR and cue history
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lfsr_q      <= LFSR_SEED;
      cue_q       <= 1'b0;
      aborted_q   <= 1'b0;
      press_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lfsr_q      <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      cue_q       <= cue_i;
      aborted_q   <= aborted_d;
      press_cnt_q <= press_cnt_d;
    end
  end
  // Next state: a zero delay jumps straight to PRESS so the press lands one cycle after the rise
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    aborted_d   = 1'b0;
    press_cnt_d = press_cnt_q;
    if (!enable_i) state_d = IDLE;
    else begin
      case (state_q)
        IDLE: begin
          state_d = cue_i ? IDLE : ARMED;
          cnt_d   = '0;
        end
        ARMED: begin
          if (rise) begin
            state_d = (dly == '0) ? PRESS : REACT;
            cnt_d   = (dly == '0) ? '0 : dly - DLY_W'(1);
          end else if (false_start_i && cnt_q == min_dly_i) begin
            state_d = PRESS;
            cnt_d   = '0;
          end else cnt_d = cnt_q + DLY_W'(1);
        end
        REACT: begin
          if (!cue_i) begin
            state_d   = ARMED;
            cnt_d     = '0;
            aborted_d = 1'b1;
          end else if (cnt_q == '0) state_d = PRESS;
          else cnt_d = cnt_q - DLY_W'(1);
        end
        PRESS: begin
          if (cnt_q == DLY_W'(HOLD_CYCLES - 1)) begin
            state_d     = RELEASE;
            press_cnt_d = press_cnt_q + 8'd1;
          end else cnt_d = cnt_q + DLY_W'(1);
        end
        RELEASE: begin
          state_d = cue_i ? RELEASE : ARMED;
          cnt_d   = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end
endmodule
